disp_num_scan: RTL and testbench

Parametrised N-digit multiplexed 7-segment display driver. It is the next generation of the team's fixed 4-digit scan display: the prescaler, digit-select scanner and hex decoder are merged into one block, with per-digit blinking added. It sits between the datapath (which supplies packed hex nibbles and per-digit control masks) and the board's common-anode display pins.

---
 rtl/disp_num_scan.sv | 105 ++++++++++
 tb/tb_disp_num_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/disp_num_scan.sv
// N-digit multiplexed common-anode 7-segment driver: prescaler, digit scanner,
// hex decoder and per-digit blinking. Optional macro DISP_LZ_BLANK_EN adds leading-zero suppression.
module disp_num_scan #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 17,
    parameter int BLINK_DIV = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   HEXS,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     LES,
    input  logic [DIGITS-1:0]     blinks,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            Segment
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [SCAN_DIV-1:0]  r_presc;
    logic [BLINK_DIV-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic [IDX_W-1:0]     r_idx;

    logic                 w_tick;
    logic [3:0]           w_nibs [DIGITS];
    logic [DIGITS-1:0]    w_lz_mask;
    logic [3:0]           w_nib;
    logic                 w_blank;
    logic [6:0]           w_seg7;

    assign w_tick = &r_presc;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign w_nibs[gi] = HEXS[4*gi +: 4];
        end
    endgenerate

`ifdef DISP_LZ_BLANK_EN
    // Digit i>0 is suppressed when it and every more-significant nibble are zero.
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lsd
                assign w_lz_mask[gi] = 1'b0;
            end else begin : g_upper
                assign w_lz_mask[gi] = ~|HEXS[4*DIGITS-1:4*gi];
            end
        end
    endgenerate
`else
    assign w_lz_mask = '0;
`endif

    assign w_nib   = w_nibs[r_idx];
    assign w_blank = LES[r_idx] | (blinks[r_idx] & r_blink_phase) | w_lz_mask[r_idx];

    always_comb begin
        w_seg7 = 7'h7F;
        case (w_nib)
            4'h0: w_seg7 = 7'h40;
            4'h1: w_seg7 = 7'h79;
            4'h2: w_seg7 = 7'h24;
            4'h3: w_seg7 = 7'h30;
            4'h4: w_seg7 = 7'h19;
            4'h5: w_seg7 = 7'h12;
            4'h6: w_seg7 = 7'h02;
            4'h7: w_seg7 = 7'h78;
            4'h8: w_seg7 = 7'h00;
            4'h9: w_seg7 = 7'h10;
            4'hA: w_seg7 = 7'h08;
            4'hB: w_seg7 = 7'h03;
            4'hC: w_seg7 = 7'h46;
            4'hD: w_seg7 = 7'h21;
            4'hE: w_seg7 = 7'h06;
            4'hF: w_seg7 = 7'h0E;
            default: w_seg7 = 7'h7F;
        endcase
    end

    // Outputs decode the pre-update idx, so they trail an idx change by one clock.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_presc       <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_idx         <= '0;
            AN            <= '1;
            Segment       <= 8'hFF;
        end else begin
            r_presc <= r_presc + 1'b1;
            if (w_tick) begin
                r_idx       <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                r_blink_cnt <= r_blink_cnt + 1'b1;
                if (&r_blink_cnt)
                    r_blink_phase <= ~r_blink_phase;
            end
            AN      <= ~(DIGITS'(1) << r_idx);
            Segment <= w_blank ? 8'hFF : {~points[r_idx], w_seg7};
        end
    end

endmodule

// File: tb/tb_disp_num_scan.sv
// Randomized self-checking bench for disp_num_scan (4-digit and 1-digit instances),
// compared against an arithmetic model of scan position and blink phase.
module tb_disp_num_scan;

    localparam int SD = 2;
    localparam int BD = 1;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] HEXS;
    logic [3:0]  points, LES, blinks;
    logic [3:0]  AN;
    logic [7:0]  Segment;
    logic [3:0]  HEXS1;
    logic        points1, LES1, blinks1;
    logic        AN1;
    logic [7:0]  Segment1;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;

    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    disp_num_scan #(.DIGITS(4), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .RST(RST), .HEXS(HEXS), .points(points), .LES(LES),
        .blinks(blinks), .AN(AN), .Segment(Segment));

    disp_num_scan #(.DIGITS(1), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut1 (
        .clk(clk), .RST(RST), .HEXS(HEXS1), .points(points1), .LES(LES1),
        .blinks(blinks1), .AN(AN1), .Segment(Segment1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [3:0] nib, input logic pt, input logic blank);
        logic [7:0] s;
        s    = SEG_TBL[nib];
        s[7] = ~pt;
        return blank ? 8'hFF : s;
    endfunction

    // Edge k (k>=1 after release) sees (k-1) prior increments, hence floor((k-1)/2^SD) ticks.
    task automatic check_edge();
        int         ticks, idx, ph;
        logic       lz;
        logic [3:0] exp_an;
        ticks  = (k - 1) >> SD;
        idx    = ticks % 4;
        ph     = (ticks >> BD) & 1;
        lz     = 1'b0;
`ifdef DISP_LZ_BLANK_EN
        lz     = (idx > 0) && ((HEXS >> (4 * idx)) == 16'h0);
`endif
        exp_an = 4'hF;
        exp_an[idx] = 1'b0;
        check("an4", 32'(AN), 32'(exp_an));
        check("seg4", 32'(Segment),
              32'(ref_seg(HEXS[4*idx +: 4], points[idx],
                          LES[idx] | (blinks[idx] & ph[0]) | lz)));
        check("an1", 32'(AN1), 32'h0);
        check("seg1", 32'(Segment1), 32'(ref_seg(HEXS1, points1, LES1 | (blinks1 & ph[0]))));
        $display("k=%0d idx=%0d ph=%0d HEXS=%h pts=%b LES=%b blk=%b -> AN=%b Seg=%h | AN1=%b Seg1=%h",
                 k, idx, ph, HEXS, points, LES, blinks, AN, Segment, AN1, Segment1);
    endtask

    task automatic randomize_inputs();
        logic [15:0] h;
        h       = 16'($urandom);
        HEXS    = h >> (4 * $urandom_range(0, 4));
        points  = 4'($urandom);
        LES     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        blinks  = 4'($urandom);
        HEXS1   = 4'($urandom);
        points1 = 1'($urandom);
        LES1    = ($urandom_range(0, 3) == 0);
        blinks1 = 1'($urandom);
    endtask

    // Inputs are held while the edge is taken and checked, then changed at the negedge.
    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) randomize_inputs();
            @(posedge clk);
            k++;
            @(negedge clk);
            check_edge();
        end
    endtask

    task automatic set_inputs(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                              input logic [3:0] b);
        HEXS = h; points = p; LES = l; blinks = b;
        HEXS1 = h[3:0]; points1 = p[0]; LES1 = l[0]; blinks1 = b[0];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an4"}, 32'(AN), 32'hF);
        check({tag, "_seg4"}, 32'(Segment), 32'hFF);
        check({tag, "_an1"}, 32'(AN1), 32'h1);
        check({tag, "_seg1"}, 32'(Segment1), 32'hFF);
        $display("reset %s: AN=%b Seg=%h AN1=%b Seg1=%h", tag, AN, Segment, AN1, Segment1);
    endtask

    initial begin
        RST = 1'b1;
        set_inputs(16'h1234, 4'h0, 4'h0, 4'h0);
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        RST = 1'b0;
        k   = 0;

        run(40, 1'b0);
        set_inputs(16'h1234, 4'b0001, 4'h0, 4'h0);  run(16, 1'b0);
        set_inputs(16'h1234, 4'h0, 4'b0010, 4'h0);  run(16, 1'b0);
        set_inputs(16'h1234, 4'b0001, 4'b0001, 4'h0); run(16, 1'b0);
        set_inputs(16'h1234, 4'h0, 4'h0, 4'b0100);  run(48, 1'b0);
        set_inputs(16'h1238, 4'h0, 4'h0, 4'hF);     run(48, 1'b0);
        set_inputs(16'h0050, 4'hF, 4'h0, 4'h0);     run(16, 1'b0);
        set_inputs(16'h0000, 4'h0, 4'h0, 4'h0);     run(16, 1'b0);
        run(150, 1'b1);

        // Asynchronous reset mid-scan: outputs clear without a clock edge.
        @(negedge clk);
        #2 RST = 1'b1;
        #1 check_reset_outputs("async");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held");
        set_inputs(16'hA5C3, 4'b0101, 4'h0, 4'h0);
        RST = 1'b0;
        k   = 0;
        run(24, 1'b0);
        run(200, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
